// File: rtl/l2_mem_responder.sv
// rtl/l2_mem_responder.sv - L2 memory responder: request queue, range check, backing-store dispatch, tagged responses
module l2_mem_responder #(
  parameter int QDEPTH         = 4,
  parameter int ADDR_LIMIT     = 1 << 20,
  parameter int MEM_ADDR_BITS  = 26,
  parameter int MEM_DATA_BITS  = 128,
  parameter int MEM_L2TAG_BITS = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      mem_req_val,
  output logic                      mem_req_rdy,
  input  logic [1:0]                mem_req_rw,
  input  logic [MEM_ADDR_BITS-1:0]  mem_req_addr,
  input  logic [MEM_DATA_BITS-1:0]  mem_req_data,
  input  logic [MEM_L2TAG_BITS-1:0] mem_req_tag,
  output logic                      mem_resp_val,
  output logic                      mem_resp_nack,
  output logic [MEM_DATA_BITS-1:0]  mem_resp_data,
  output logic [MEM_L2TAG_BITS-1:0] mem_resp_tag,
  output logic                      back_req_val,
  input  logic                      back_req_rdy,
  output logic                      back_req_rw,
  output logic [MEM_ADDR_BITS-1:0]  back_req_addr,
  output logic [MEM_DATA_BITS-1:0]  back_req_data,
  input  logic                      back_resp_val,
  input  logic [MEM_DATA_BITS-1:0]  back_resp_data
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL    = CW'(QDEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [63:0]   LIMIT   = 64'(ADDR_LIMIT);

  // Request queue storage; the source (HTIF) bit has no effect on ordering or routing
  logic                      rq_wr   [QDEPTH];
  logic [MEM_ADDR_BITS-1:0]  rq_addr [QDEPTH];
  logic [MEM_DATA_BITS-1:0]  rq_data [QDEPTH];
  logic [MEM_L2TAG_BITS-1:0] rq_tag  [QDEPTH];
  logic [PW-1:0]             rq_wr_ptr, rq_rd_ptr;
  logic [CW-1:0]             rq_count;

  // Pending-read tag queue, popped in backend return order
  logic [MEM_L2TAG_BITS-1:0] tq_tag [QDEPTH];
  logic [PW-1:0]             tq_wr_ptr, tq_rd_ptr;
  logic [CW-1:0]             tq_count;

  logic unused_htif;
  assign unused_htif = mem_req_rw[1];

  logic rq_nonempty, tq_nonempty, tq_full, head_oor, head_read;
  logic rq_push, rq_pop, tq_push, tq_pop, dispatch, resp_fire, nack_pop;

  assign rq_nonempty = (rq_count != '0);
  assign tq_nonempty = (tq_count != '0);
  assign tq_full     = (tq_count == FULL);
  assign head_oor    = (64'(rq_addr[rq_rd_ptr]) >= LIMIT);
  assign head_read   = ~rq_wr[rq_rd_ptr];

  assign mem_req_rdy   = (rq_count != FULL);
  assign back_req_val  = rq_nonempty & ~head_oor & ~(head_read & tq_full);
  assign back_req_rw   = rq_wr[rq_rd_ptr];
  assign back_req_addr = rq_addr[rq_rd_ptr];
  assign back_req_data = rq_data[rq_rd_ptr];

  // A backend return takes the response slot; an out-of-range head waits for a free cycle
  assign rq_push   = mem_req_val & mem_req_rdy;
  assign dispatch  = back_req_val & back_req_rdy;
  assign resp_fire = back_resp_val & tq_nonempty;
  assign nack_pop  = rq_nonempty & head_oor & ~resp_fire;
  assign rq_pop    = dispatch | nack_pop;
  assign tq_push   = dispatch & head_read;
  assign tq_pop    = resp_fire;

  // Capture accepted requests into the request queue
  always_ff @(posedge clk) begin
    if (rq_push) begin
      rq_wr[rq_wr_ptr]   <= mem_req_rw[0];
      rq_addr[rq_wr_ptr] <= mem_req_addr;
      rq_data[rq_wr_ptr] <= mem_req_data;
      rq_tag[rq_wr_ptr]  <= mem_req_tag;
    end
  end

  // Record the tag of each read handed to the backend
  always_ff @(posedge clk) begin
    if (tq_push) tq_tag[tq_wr_ptr] <= rq_tag[rq_rd_ptr];
  end

  // Queue pointers and occupancy; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rq_wr_ptr <= '0;
      rq_rd_ptr <= '0;
      rq_count  <= '0;
      tq_wr_ptr <= '0;
      tq_rd_ptr <= '0;
      tq_count  <= '0;
    end else begin
      if (rq_push) rq_wr_ptr <= rq_wr_ptr + PTR_ONE;
      if (rq_pop)  rq_rd_ptr <= rq_rd_ptr + PTR_ONE;
      if (rq_push && !rq_pop)      rq_count <= rq_count + CNT_ONE;
      else if (!rq_push && rq_pop) rq_count <= rq_count - CNT_ONE;
      if (tq_push) tq_wr_ptr <= tq_wr_ptr + PTR_ONE;
      if (tq_pop)  tq_rd_ptr <= tq_rd_ptr + PTR_ONE;
      if (tq_push && !tq_pop)      tq_count <= tq_count + CNT_ONE;
      else if (!tq_push && tq_pop) tq_count <= tq_count - CNT_ONE;
    end
  end

  // Registered single-cycle response: backend data or a refusal of an out-of-range request
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_resp_val  <= 1'b0;
      mem_resp_nack <= 1'b0;
      mem_resp_data <= '0;
      mem_resp_tag  <= '0;
    end else begin
      mem_resp_val  <= resp_fire | nack_pop;
      mem_resp_nack <= nack_pop;
      if (resp_fire) begin
        mem_resp_data <= back_resp_data;
        mem_resp_tag  <= tq_tag[tq_rd_ptr];
      end else if (nack_pop) begin
        mem_resp_data <= '0;
        mem_resp_tag  <= rq_tag[rq_rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_l2_mem_responder.sv
// tb/tb_l2_mem_responder.sv - self-checking bench for l2_mem_responder
module tb_l2_mem_responder;

  localparam int QD  = 4;
  localparam int LIM = 1 << 20;
  localparam int AW  = 26;
  localparam int DW  = 32;
  localparam int TW  = 5;

  logic          clk;
  logic          reset_n;
  logic          mem_req_val, mem_req_rdy;
  logic [1:0]    mem_req_rw;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_data;
  logic [TW-1:0] mem_req_tag;
  logic          mem_resp_val, mem_resp_nack;
  logic [DW-1:0] mem_resp_data;
  logic [TW-1:0] mem_resp_tag;
  logic          back_req_val, back_req_rdy, back_req_rw;
  logic [AW-1:0] back_req_addr;
  logic [DW-1:0] back_req_data;
  logic          back_resp_val;
  logic [DW-1:0] back_resp_data;

  l2_mem_responder #(
    .QDEPTH(QD), .ADDR_LIMIT(LIM), .MEM_ADDR_BITS(AW), .MEM_DATA_BITS(DW), .MEM_L2TAG_BITS(TW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_rw(mem_req_rw),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_resp_val(mem_resp_val), .mem_resp_nack(mem_resp_nack),
    .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag),
    .back_req_val(back_req_val), .back_req_rdy(back_req_rdy), .back_req_rw(back_req_rw),
    .back_req_addr(back_req_addr), .back_req_data(back_req_data),
    .back_resp_val(back_resp_val), .back_resp_data(back_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // transaction-level reference state
  logic [DW-1:0]    ref_mem [int];
  logic [DW-1:0]    be_mem  [int];
  logic [DW+TW-1:0] exp_data_q [$];
  logic [TW-1:0]    exp_nack_q [$];
  logic [AW+DW:0]   exp_disp_q [$];
  logic [DW-1:0]    pend_data  [$];
  int               pend_rdy   [$];
  bit               use_model, prev_fire, req_pending;
  int               rdy_pct, resp_seen;
  logic [1:0]       req_rw;
  logic [AW-1:0]    req_addr;
  logic [DW-1:0]    req_data;
  logic [TW-1:0]    req_tag;

  typedef struct {
    logic [1:0]    rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    bit            disp;
    int            kind;
    logic [DW-1:0] edata;
    logic [TW-1:0] etag;
  } vec_t;
  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {6'h2a, a} ^ 32'h5A5A0000;
  endfunction

  function automatic bit drained();
    return !req_pending && exp_data_q.size() == 0 && exp_nack_q.size() == 0 &&
           exp_disp_q.size() == 0 && pend_data.size() == 0;
  endfunction

  task automatic model_accept();
    int a;
    a = int'(req_addr);
    if (a >= LIM) exp_nack_q.push_back(req_tag);
    else begin
      exp_disp_q.push_back({req_rw[0], req_addr, (req_rw[0] ? req_data : {DW{1'b0}})});
      if (req_rw[0]) ref_mem[a] = req_data;
      else exp_data_q.push_back({(ref_mem.exists(a) ? ref_mem[a] : init_val(req_addr)), req_tag});
    end
  endtask

  task automatic step_auto();
    logic [DW+TW-1:0] e;
    logic [AW+DW:0]   act;
    int               a;
    @(negedge clk);
    cyc++;
    if (prev_fire) begin
      check("resp_val_after_back_resp", mem_resp_val, 1);
      check("resp_nack_on_data", mem_resp_nack, 0);
      if (exp_data_q.size() == 0) fail_now("unexpected data response");
      else begin
        e = exp_data_q.pop_front();
        check("resp_data", mem_resp_data, e[DW+TW-1:TW]);
        check("resp_tag", mem_resp_tag, e[TW-1:0]);
      end
      resp_seen++;
    end else if (mem_resp_val) begin
      check("resp_is_nack", mem_resp_nack, 1);
      if (exp_nack_q.size() == 0) fail_now("unexpected nack response");
      else begin
        check("nack_tag", mem_resp_tag, exp_nack_q.pop_front());
        check("nack_data", mem_resp_data, 0);
      end
      resp_seen++;
    end
    back_req_rdy   = ($urandom_range(99) < rdy_pct);
    back_resp_val  = 1'b0;
    back_resp_data = $urandom;
    prev_fire      = 1'b0;
    if (pend_data.size() > 0 && pend_rdy[0] <= cyc && $urandom_range(3) != 0) begin
      back_resp_val  = 1'b1;
      back_resp_data = pend_data.pop_front();
      pend_rdy.delete(0);
      prev_fire      = 1'b1;
    end
    mem_req_val  = req_pending;
    mem_req_rw   = req_rw;
    mem_req_addr = req_addr;
    mem_req_data = req_data;
    mem_req_tag  = req_tag;
    #1;
    if (mem_req_val && mem_req_rdy) begin
      req_pending = 1'b0;
      if (use_model) model_accept();
    end
    if (back_req_val && back_req_rdy) begin
      act = {back_req_rw, back_req_addr, (back_req_rw ? back_req_data : {DW{1'b0}})};
      if (exp_disp_q.size() == 0) fail_now("unexpected dispatch");
      else check("dispatch", act, exp_disp_q.pop_front());
      a = int'(back_req_addr);
      if (back_req_rw) be_mem[a] = back_req_data;
      else begin
        pend_data.push_back(be_mem.exists(a) ? be_mem[a] : init_val(back_req_addr));
        pend_rdy.push_back(cyc + int'($urandom_range(1, 4)));
      end
    end
  endtask

  task automatic mcycle(input logic v, input logic [1:0] rw, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [TW-1:0] t,
                        input logic rdy, input logic rv, input logic [DW-1:0] rd);
    @(negedge clk);
    mem_req_val    = v;
    mem_req_rw     = rw;
    mem_req_addr   = a;
    mem_req_data   = d;
    mem_req_tag    = t;
    back_req_rdy   = rdy;
    back_resp_val  = rv;
    back_resp_data = rd;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n       = 1'b0;
    mem_req_val   = 1'b0;
    back_req_rdy  = 1'b0;
    back_resp_val = 1'b0;
    exp_data_q.delete();
    exp_nack_q.delete();
    exp_disp_q.delete();
    pend_data.delete();
    pend_rdy.delete();
    prev_fire   = 1'b0;
    req_pending = 1'b0;
    #1;
    check("reset_req_rdy", mem_req_rdy, 1);
    check("reset_back_req_val", back_req_val, 0);
    check("reset_resp_val", mem_resp_val, 0);
    check("reset_resp_nack", mem_resp_nack, 0);
    check("reset_resp_data", mem_resp_data, 0);
    check("reset_resp_tag", mem_resp_tag, 0);
    repeat (2) @(negedge clk);
    check("reset_req_rdy_held", mem_req_rdy, 1);
    reset_n = 1'b1;
  endtask

  task automatic seq_read_latency();
    do_reset();
    mcycle(1, 2'b00, 26'h40, 0, 5'h15, 0, 0, 0);
    check("lat_rdy_before_push", mem_req_rdy, 1);
    mcycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("lat_head_visible", back_req_val, 1);
    check("lat_head_rw", back_req_rw, 0);
    check("lat_head_addr", back_req_addr, 32'h40);
    mcycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("lat_queue_empty", back_req_val, 0);
    mcycle(0, 0, 0, 0, 0, 1, 1, 32'hA5);
    check("lat_no_early_resp", mem_resp_val, 0);
    mcycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("lat_resp_val", mem_resp_val, 1);
    check("lat_resp_nack", mem_resp_nack, 0);
    check("lat_resp_data", mem_resp_data, 32'hA5);
    check("lat_resp_tag", mem_resp_tag, 5'h15);
    mcycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("lat_resp_pulse", mem_resp_val, 0);
  endtask

  task automatic seq_nack_timing();
    do_reset();
    mcycle(1, 2'b00, AW'(LIM), 0, 5'h3, 1, 0, 0);
    mcycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("oor_not_dispatched", back_req_val, 0);
    check("oor_no_resp_yet", mem_resp_val, 0);
    mcycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("oor_resp_val", mem_resp_val, 1);
    check("oor_resp_nack", mem_resp_nack, 1);
    check("oor_resp_data", mem_resp_data, 0);
    check("oor_resp_tag", mem_resp_tag, 5'h3);
    mcycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("oor_resp_pulse", mem_resp_val, 0);
    check("oor_never_dispatched", back_req_val, 0);
  endtask

  task automatic seq_backpressure();
    int disp, given, got, acc_k;
    bit pend5, rv;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mcycle(1, 2'b00, AW'(32'h100 + i), 0, TW'(i), 0, 0, 0);
      check($sformatf("bp_rdy_push%0d", i), mem_req_rdy, 1);
    end
    mcycle(1, 2'b00, 26'h104, 0, 5'd4, 0, 0, 0);
    check("bp_rdy_full", mem_req_rdy, 0);
    mcycle(1, 2'b00, 26'h104, 0, 5'd4, 0, 0, 0);
    check("bp_rdy_still_full", mem_req_rdy, 0);
    check("bp_head_held", back_req_addr, 32'h100);
    disp = 0; given = 0; got = 0; acc_k = -1; pend5 = 1'b1;
    for (int k = 0; k < 30; k++) begin
      rv = (given < disp);
      mcycle(pend5, 2'b00, 26'h104, 0, 5'd4, 1, rv, 32'hC0DE);
      if (rv) given++;
      if (mem_resp_val) begin
        check("bp_resp_nack", mem_resp_nack, 0);
        check($sformatf("bp_resp_tag%0d", got), mem_resp_tag, got);
        got++;
      end
      if (pend5 && mem_req_rdy) begin
        pend5 = 1'b0;
        acc_k = k;
      end
      if (back_req_val) begin
        check($sformatf("bp_disp_addr%0d", disp), back_req_addr, 32'h100 + disp);
        disp++;
      end
    end
    check("bp_fifth_accept_cycle", acc_k, 1);
    check("bp_disp_count", disp, 5);
    check("bp_resp_count", got, 5);
  endtask

  task automatic seq_collision();
    do_reset();
    mcycle(1, 2'b00, 26'h20, 0, 5'd5, 1, 0, 0);
    mcycle(1, 2'b00, AW'(LIM), 0, 5'd6, 1, 0, 0);
    check("col_read_dispatch", back_req_val, 1);
    check("col_read_addr", back_req_addr, 32'h20);
    mcycle(0, 0, 0, 0, 0, 1, 1, 32'h55);
    check("col_oor_held", back_req_val, 0);
    check("col_no_resp_yet", mem_resp_val, 0);
    mcycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("col_first_val", mem_resp_val, 1);
    check("col_first_nack", mem_resp_nack, 0);
    check("col_first_data", mem_resp_data, 32'h55);
    check("col_first_tag", mem_resp_tag, 5'd5);
    mcycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("col_second_val", mem_resp_val, 1);
    check("col_second_nack", mem_resp_nack, 1);
    check("col_second_data", mem_resp_data, 0);
    check("col_second_tag", mem_resp_tag, 5'd6);
    mcycle(0, 0, 0, 0, 0, 1, 0, 0);
    check("col_pulse_end", mem_resp_val, 0);
  endtask

  task automatic seq_reset_midop();
    do_reset();
    mcycle(1, 2'b00, 26'h30, 0, 5'd1, 1, 0, 0);
    mcycle(1, 2'b00, 26'h31, 0, 5'd2, 1, 0, 0);
    mcycle(1, 2'b00, 26'h32, 0, 5'd3, 1, 0, 0);
    mcycle(1, 2'b01, 26'h33, 32'h99, 5'd4, 1, 0, 0);
    mcycle(1, 2'b00, 26'h34, 0, 5'd5, 0, 0, 0);
    mcycle(1, 2'b00, 26'h35, 0, 5'd6, 0, 1, 32'hEE);
    mcycle(0, 0, 0, 0, 0, 0, 0, 0);
    check("mid_resp_before_reset", mem_resp_val, 1);
    check("mid_queue_busy", back_req_val, 1);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      mcycle(0, 0, 0, 0, 0, 1, (k < 2), 32'h1234);
      check($sformatf("mid_no_resp%0d", k), mem_resp_val, 0);
      check($sformatf("mid_no_dispatch%0d", k), back_req_val, 0);
    end
  endtask

  task automatic gen_req();
    req_rw = 2'($urandom_range(3));
    case ($urandom_range(9))
      0:       req_addr = AW'(LIM - 2 + int'($urandom_range(3)));
      1:       req_addr = AW'($urandom);
      default: req_addr = AW'($urandom_range(63));
    endcase
    req_data    = $urandom;
    req_tag     = TW'($urandom);
    req_pending = 1'b1;
  endtask

  initial begin
    int idle_n;
    reset_n = 1'b1;
    mem_req_val = 0; mem_req_rw = 0; mem_req_addr = 0; mem_req_data = 0; mem_req_tag = 0;
    back_req_rdy = 0; back_resp_val = 0; back_resp_data = 0;
    prev_fire = 0; req_pending = 0; use_model = 0; rdy_pct = 100; resp_seen = 0;
    req_rw = 0; req_addr = 0; req_data = 0; req_tag = 0;

    vecs[0] = '{2'b01, 26'h10, 32'h77, 5'h01, 1'b1, 0, 32'h0, 5'h0};
    vecs[1] = '{2'b01, 26'h40, 32'hA5, 5'h02, 1'b1, 0, 32'h0, 5'h0};
    vecs[2] = '{2'b00, 26'h40, 32'h0, 5'h15, 1'b1, 1, 32'hA5, 5'h15};
    vecs[3] = '{2'b00, 26'h10, 32'h0, 5'h0A, 1'b1, 1, 32'h77, 5'h0A};
    vecs[4] = '{2'b00, AW'(LIM), 32'h0, 5'h03, 1'b0, 2, 32'h0, 5'h03};
    vecs[5] = '{2'b11, AW'(LIM - 1), 32'hDEADBEEF, 5'h04, 1'b1, 0, 32'h0, 5'h0};
    vecs[6] = '{2'b10, AW'(LIM - 1), 32'h0, 5'h1F, 1'b1, 1, 32'hDEADBEEF, 5'h1F};
    vecs[7] = '{2'b01, AW'(LIM), 32'h1234, 5'h07, 1'b0, 2, 32'h0, 5'h07};
    vecs[8] = '{2'b00, 26'h3FFFFFF, 32'h0, 5'h11, 1'b0, 2, 32'h0, 5'h11};
    vecs[9] = '{2'b10, 26'h10, 32'h0, 5'h1E, 1'b1, 1, 32'h77, 5'h1E};

    do_reset();
    use_model = 0;
    rdy_pct   = 100;
    for (int i = 0; i < 10; i++) begin
      req_rw = vecs[i].rw; req_addr = vecs[i].addr; req_data = vecs[i].data; req_tag = vecs[i].tag;
      req_pending = 1'b1;
      if (vecs[i].disp)
        exp_disp_q.push_back({vecs[i].rw[0], vecs[i].addr, (vecs[i].rw[0] ? vecs[i].data : {DW{1'b0}})});
      if (vecs[i].kind == 1) exp_data_q.push_back({vecs[i].edata, vecs[i].etag});
      else if (vecs[i].kind == 2) exp_nack_q.push_back(vecs[i].etag);
      resp_seen = 0;
      idle_n = 0;
      for (int k = 0; k < 40 && idle_n < 4; k++) begin
        step_auto();
        if (drained()) idle_n++;
        else idle_n = 0;
      end
      check($sformatf("vec%0d_drained", i), drained(), 1);
      check($sformatf("vec%0d_resp_count", i), resp_seen, (vecs[i].kind != 0) ? 1 : 0);
    end

    seq_read_latency();
    seq_nack_timing();
    seq_backpressure();
    seq_collision();
    seq_reset_midop();

    do_reset();
    ref_mem.delete();
    be_mem.delete();
    use_model = 1;
    rdy_pct   = 70;
    for (int k = 0; k < 600; k++) begin
      if (!req_pending && $urandom_range(9) < 6) gen_req();
      step_auto();
    end
    for (int k = 0; k < 300 && !drained(); k++) step_auto();
    repeat (4) step_auto();
    check("rand_drained", drained(), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
